retention_monitor: RTL and testbench
====================================

Name: retention_monitor

Overview:
- Multi-channel retention verification monitor for power-gated domains.
- Each channel is sequenced through save / power-down / power-up / restore by its own FSM.
- After a programmable restore latency, restored data is compared against the saved snapshot.
- Reports sticky mismatch and protocol errors, saturating fail counters, and per-check done pulses.
- Sits alongside the power controller in verification and silicon-debug builds.

Parameters:
WIDTH, 32, data bits per channel
NCH, 4, number of independent retention channels
CNT_W, 8, width of each per-channel fail counter
RESTORE_LAT, 1, extra cycles between sampled restore and compare (0..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of sticky errors and fail counters
save  in  NCH  per-channel save strobe, sampled on posedge clk
restore  in  NCH  per-channel restore strobe
pwr_on  in  NCH  per-channel domain power status (1 = powered)
data  in  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
err_mismatch  out  NCH  sticky: restored data differed from the snapshot
err_proto  out  NCH  sticky: illegal sequence detected
fail_cnt  out  NCH*CNT_W  per-channel saturating mismatch count, [c*CNT_W +: CNT_W]
chk_done  out  NCH  one-cycle pulse when a compare is performed
ch_state  out  NCH*3  per-channel FSM state, [c*3 +: 3]
irq  out  1  OR of all err_mismatch and err_proto bits

Behaviour:
Reset and timing
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- During reset: all outputs 0, every ch_state = ACTIVE, snapshots 0, snapshot-valid bits 0.
- All outputs are registered. irq is registered from the next-state error bits, so it tracks err_* in the same cycle.

Channels
- Channels are fully independent; the rules below are per channel.

FSM encoding
- ACTIVE=0, SAVED=1, OFF=2, WAKE=3, CHECK=4.

Priority
- pwr_on==0 in any state other than OFF is evaluated first. Remaining conditions are evaluated in the order listed.

Transitions
- ACTIVE:
  - pwr_on low -> OFF, err_proto set (power-down without save), valid cleared.
  - save -> SAVED, snapshot <= data, valid set.
  - restore alone -> err_proto set, stay.
- SAVED:
  - pwr_on low -> OFF.
  - save -> re-capture snapshot, stay.
  - restore -> CHECK (software restore without power cycle is legal).
- OFF:
  - save or restore asserted -> err_proto set, stay.
  - pwr_on high -> WAKE. Strobes sampled in the same cycle are ignored.
- WAKE:
  - pwr_on low -> OFF.
  - save -> err_proto set, stay; snapshot is NOT overwritten.
  - restore -> CHECK, lat_cnt <= RESTORE_LAT.
- CHECK:
  - pwr_on low -> OFF, err_proto set, compare aborted, no chk_done.
  - lat_cnt != 0 -> decrement.
  - lat_cnt == 0 -> compare data against snapshot, pulse chk_done, go to ACTIVE.
  - On compare, if valid and data != snapshot: set err_mismatch, increment fail_cnt.
  - If valid == 0: chk_done still pulses, no mismatch is flagged, and err_proto is set.
  - save and restore are ignored while in CHECK.
- Save and restore asserted together in ACTIVE or SAVED: save wins, restore is dropped with no error.

Compare timing
- The compare uses data sampled RESTORE_LAT+1 cycles after the cycle in which restore was sampled.

Counters and clear
- fail_cnt saturates at 2^CNT_W-1; no wrap.
- clr zeroes err_*, fail_cnt and irq next cycle; the FSM, snapshot and valid are unaffected.
- clr and a new error in the same cycle: the error wins (bit set, counter = 1).

Reset mid-operation
- Any state returns to ACTIVE immediately and the snapshot is lost.

Test Plan:
- Clean cycle, ch0, RESTORE_LAT=1: save with data=0xDEADBEEF, pwr_on 1->0->1, restore, hold data -> chk_done pulses 2 cycles after restore; err_mismatch=0, fail_cnt=0; ch_state sequence 1,2,3,4,4,0.
- Corruption, ch1: save 0x12345678, power cycle, data=0x12345679 at compare -> err_mismatch[1]=1, fail_cnt[1]=1, irq=1; other channels remain 0.
- Protocol errors, ch2: drop pwr_on in ACTIVE without save -> err_proto[2]=1, state OFF; restore while OFF -> err_proto stays 1; after WAKE+restore, chk_done pulses and err_mismatch[2]=0.
- Saturation/clear, CNT_W=2: 5 corrupted cycles -> fail_cnt=3; clr in the same cycle as a 6th mismatch -> fail_cnt=1, err_mismatch=1.
- Abort, ch3, RESTORE_LAT=3: pwr_on drops 2 cycles into CHECK -> err_proto=1, state OFF, no chk_done, fail_cnt unchanged.
- Async reset asserted in CHECK -> all outputs 0 immediately; after release, restore in ACTIVE -> err_proto=1.

Source files
------------

// File: rtl/retention_monitor.sv
// Multi-channel retention monitor: each channel tracks save / power-down / wake / restore,
// compares restored data against the saved snapshot and reports sticky errors and counts.
module retention_monitor #(
  parameter int WIDTH       = 32,
  parameter int NCH         = 4,
  parameter int CNT_W       = 8,
  parameter int RESTORE_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [NCH-1:0]         save,
  input  logic [NCH-1:0]         restore,
  input  logic [NCH-1:0]         pwr_on,
  input  logic [NCH*WIDTH-1:0]   data,
  output logic [NCH-1:0]         err_mismatch,
  output logic [NCH-1:0]         err_proto,
  output logic [NCH*CNT_W-1:0]   fail_cnt,
  output logic [NCH-1:0]         chk_done,
  output logic [NCH*3-1:0]       ch_state,
  output logic                   irq
);

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'd0,
    ST_SAVED  = 3'd1,
    ST_OFF    = 3'd2,
    ST_WAKE   = 3'd3,
    ST_CHECK  = 3'd4
  } state_t;

  localparam logic [3:0]       LAT_INIT = 4'(RESTORE_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Next-cycle sticky error bits, shared so irq can be registered in step with err_*.
  logic [NCH-1:0] em_nxt;
  logic [NCH-1:0] ep_nxt;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t           state_q;
    logic [WIDTH-1:0] snap_q;
    logic             valid_q;
    logic [3:0]       lat_q;
    logic             em_q;
    logic             ep_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] din;
    logic             proto_evt;
    logic             mis_evt;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_nxt;

    assign din = data[c*WIDTH +: WIDTH];

    // Error events for this cycle, derived from the same priority order the FSM uses.
    always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      proto_evt = 1'b0;
      mis_evt   = 1'b0;
      case (state_q)
        ST_ACTIVE: proto_evt = !pwr_on[c] || (!save[c] && restore[c]);
        ST_OFF:    proto_evt = !pwr_on[c] && (save[c] || restore[c]);
        ST_WAKE:   proto_evt = pwr_on[c] && save[c];
        ST_CHECK: begin
          if (!pwr_on[c]) begin
            proto_evt = 1'b1;
          end else if (lat_q == '0) begin
            proto_evt = !valid_q;
            mis_evt   = valid_q && (din != snap_q);
          end
        end
        default: ;
      endcase
    end

    // A new error in the clear cycle wins over the clear.
    always_comb begin
      cnt_base = clr ? '0 : cnt_q;
      cnt_nxt  = cnt_base;
      if (mis_evt && cnt_base != CNT_MAX) cnt_nxt = cnt_base + CNT_W'(1);
    end

    assign em_nxt[c] = (em_q & ~clr) | mis_evt;
    assign ep_nxt[c] = (ep_q & ~clr) | proto_evt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_ACTIVE;
        // NOTE: the snapshot is reset too, since a lost snapshot must read back as zero.
        snap_q  <= '0;
        valid_q <= 1'b0;
        lat_q   <= '0;
        em_q    <= 1'b0;
        ep_q    <= 1'b0;
        done_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        // NOTE: non-blocking throughout so every register sees pre-edge values.
        em_q   <= em_nxt[c];
        ep_q   <= ep_nxt[c];
        cnt_q  <= cnt_nxt;
        done_q <= 1'b0;
        case (state_q)
          ST_ACTIVE: begin
            if (!pwr_on[c]) begin
              state_q <= ST_OFF;
              valid_q <= 1'b0;
            end else if (save[c]) begin
              state_q <= ST_SAVED;
              snap_q  <= din;
              valid_q <= 1'b1;
            end
          end
          ST_SAVED: begin
            if (!pwr_on[c]) begin
              state_q <= ST_OFF;
            end else if (save[c]) begin
              snap_q <= din;
            end else if (restore[c]) begin
              state_q <= ST_CHECK;
              lat_q   <= LAT_INIT;
            end
          end
          ST_OFF: begin
            if (pwr_on[c]) state_q <= ST_WAKE;
          end
          ST_WAKE: begin
            if (!pwr_on[c]) begin
              state_q <= ST_OFF;
            end else if (!save[c] && restore[c]) begin
              state_q <= ST_CHECK;
              lat_q   <= LAT_INIT;
            end
          end
          ST_CHECK: begin
            if (!pwr_on[c]) begin
              state_q <= ST_OFF;
            end else if (lat_q != '0) begin
              lat_q <= lat_q - 4'd1;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_ACTIVE;
            end
          end
          default: state_q <= ST_ACTIVE;
        endcase
      end
    end

    assign err_mismatch[c]           = em_q;
    assign err_proto[c]              = ep_q;
    assign chk_done[c]               = done_q;
    assign fail_cnt[c*CNT_W +: CNT_W] = cnt_q;
    assign ch_state[c*3 +: 3]         = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |(em_nxt | ep_nxt);
  end

endmodule

// File: tb/tb_retention_monitor.sv
// Bench for retention_monitor: two instances (LAT=1/CNT_W=8 and LAT=3/CNT_W=2) share directed
// stimulus; a behavioural model is compared every cycle, plus hand-computed literal checks.
module tb_retention_monitor;

  localparam int NCH = 4;
  localparam int W   = 32;

  localparam int ACTIVE = 0, SAVED = 1, OFF = 2, WAKE = 3, CHECK = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clr = 1'b0;
  logic [3:0]     save = '0;
  logic [3:0]     restore = '0;
  logic [3:0]     pwr_on = 4'hF;
  logic [127:0]   data = '0;

  logic [3:0]  em_a, ep_a, done_a, em_b, ep_b, done_b;
  logic [31:0] cnt_a;
  logic [7:0]  cnt_b;
  logic [11:0] st_a, st_b;
  logic        irq_a, irq_b;

  int total = 0;
  int bad   = 0;

  retention_monitor #(.WIDTH(W), .NCH(NCH), .CNT_W(8), .RESTORE_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .save(save), .restore(restore), .pwr_on(pwr_on),
    .data(data), .err_mismatch(em_a), .err_proto(ep_a), .fail_cnt(cnt_a), .chk_done(done_a),
    .ch_state(st_a), .irq(irq_a));

  retention_monitor #(.WIDTH(W), .NCH(NCH), .CNT_W(2), .RESTORE_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .save(save), .restore(restore), .pwr_on(pwr_on),
    .data(data), .err_mismatch(em_b), .err_proto(ep_b), .fail_cnt(cnt_b), .chk_done(done_b),
    .ch_state(st_b), .irq(irq_b));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic         s_rst_n, s_clr;
  logic [3:0]   s_save, s_restore, s_pwr;
  logic [127:0] s_data;
  always @(posedge clk) begin
    s_rst_n   <= rst_n;
    s_clr     <= clr;
    s_save    <= save;
    s_restore <= restore;
    s_pwr     <= pwr_on;
    s_data    <= data;
  end

  // Behavioural model, instance 0 = dut_a, 1 = dut_b.
  int          m_st  [2][4];
  logic [31:0] m_snap[2][4];
  bit          m_vld [2][4];
  int          m_lat [2][4];
  bit          m_em  [2][4];
  bit          m_ep  [2][4];
  bit          m_done[2][4];
  int          m_cnt [2][4];
  int          lat_p [2] = '{1, 3};
  int          cmax  [2] = '{255, 3};
  int          cw    [2] = '{8, 2};

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < NCH; c++) begin
        m_st[i][c] = ACTIVE; m_snap[i][c] = '0; m_vld[i][c] = 0; m_lat[i][c] = 0;
        m_em[i][c] = 0; m_ep[i][c] = 0; m_done[i][c] = 0; m_cnt[i][c] = 0;
      end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < NCH; c++) begin
        bit p, sv, rs, pe, me;
        logic [31:0] d;
        p = s_pwr[c]; sv = s_save[c]; rs = s_restore[c]; d = s_data[c*W +: W];
        pe = 0; me = 0;
        m_done[i][c] = 0;
        case (m_st[i][c])
          ACTIVE: if (!p) begin m_st[i][c] = OFF; pe = 1; m_vld[i][c] = 0; end
                  else if (sv) begin m_st[i][c] = SAVED; m_snap[i][c] = d; m_vld[i][c] = 1; end
                  else if (rs) pe = 1;
          SAVED:  if (!p) m_st[i][c] = OFF;
                  else if (sv) m_snap[i][c] = d;
                  else if (rs) begin m_st[i][c] = CHECK; m_lat[i][c] = lat_p[i]; end
          OFF:    if (p) m_st[i][c] = WAKE;
                  else if (sv || rs) pe = 1;
          WAKE:   if (!p) m_st[i][c] = OFF;
                  else if (sv) pe = 1;
                  else if (rs) begin m_st[i][c] = CHECK; m_lat[i][c] = lat_p[i]; end
          default: begin
            if (!p) begin m_st[i][c] = OFF; pe = 1; end
            else if (m_lat[i][c] > 0) m_lat[i][c]--;
            else begin
              m_done[i][c] = 1;
              m_st[i][c] = ACTIVE;
              if (!m_vld[i][c]) pe = 1;
              else if (d != m_snap[i][c]) me = 1;
            end
          end
        endcase
        if (s_clr) begin m_em[i][c] = 0; m_ep[i][c] = 0; m_cnt[i][c] = 0; end
        if (me) begin
          m_em[i][c] = 1;
          if (m_cnt[i][c] < cmax[i]) m_cnt[i][c]++;
        end
        if (pe) m_ep[i][c] = 1;
      end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic [63:0] e_em, e_ep, e_done, e_cnt, e_st, e_irq;
      string nm;
      e_em = '0; e_ep = '0; e_done = '0; e_cnt = '0; e_st = '0;
      for (int c = 0; c < NCH; c++) begin
        e_em[c]   = m_em[i][c];
        e_ep[c]   = m_ep[i][c];
        e_done[c] = m_done[i][c];
        e_cnt    |= 64'(m_cnt[i][c]) << (c * cw[i]);
        e_st     |= 64'(m_st[i][c]) << (c * 3);
      end
      e_irq = 64'(|(e_em | e_ep));
      nm = (i == 0) ? "a" : "b";
      check({nm, ".err_mismatch"}, (i == 0) ? 64'(em_a)   : 64'(em_b),   e_em);
      check({nm, ".err_proto"},    (i == 0) ? 64'(ep_a)   : 64'(ep_b),   e_ep);
      check({nm, ".chk_done"},     (i == 0) ? 64'(done_a) : 64'(done_b), e_done);
      check({nm, ".fail_cnt"},     (i == 0) ? 64'(cnt_a)  : 64'(cnt_b),  e_cnt);
      check({nm, ".ch_state"},     (i == 0) ? 64'(st_a)   : 64'(st_b),   e_st);
      check({nm, ".irq"},          (i == 0) ? 64'(irq_a)  : 64'(irq_b),  e_irq);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n || !s_rst_n) model_reset();
      else model_step();
      compare_all();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_n(input int n);
    repeat (n) cyc();
  endtask

  task automatic set_data(input int c, input logic [31:0] v);
    data[c*W +: W] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    wait_n(2);
    check("reset.ch_state_a", 64'(st_a), 64'h0);
    check("reset.irq_a", 64'(irq_a), 64'h0);
    check("reset.fail_cnt_b", 64'(cnt_b), 64'h0);
    rst_n = 1'b1;
    cyc();

    // Clean cycle on ch0
    set_data(0, 32'hDEADBEEF);
    save[0] = 1'b1; cyc(); save[0] = 1'b0;
    check("clean.state_saved", 64'(st_a[2:0]), 64'd1);
    pwr_on[0] = 1'b0; cyc();
    check("clean.state_off", 64'(st_a[2:0]), 64'd2);
    pwr_on[0] = 1'b1; cyc();
    check("clean.state_wake", 64'(st_a[2:0]), 64'd3);
    restore[0] = 1'b1; cyc(); restore[0] = 1'b0;
    check("clean.state_check1", 64'(st_a[2:0]), 64'd4);
    cyc();
    check("clean.state_check2", 64'(st_a[2:0]), 64'd4);
    check("clean.no_early_done", 64'(done_a), 64'h0);
    cyc();
    check("clean.state_active", 64'(st_a[2:0]), 64'd0);
    check("clean.chk_done", 64'(done_a), 64'h1);
    check("clean.err_mismatch", 64'(em_a), 64'h0);
    check("clean.fail_cnt", 64'(cnt_a), 64'h0);
    wait_n(3);

    // Corruption on ch1
    set_data(1, 32'h12345678);
    save[1] = 1'b1; cyc(); save[1] = 1'b0;
    pwr_on[1] = 1'b0; cyc();
    pwr_on[1] = 1'b1; cyc();
    set_data(1, 32'h12345679);
    restore[1] = 1'b1; cyc(); restore[1] = 1'b0;
    wait_n(2);
    check("corrupt.err_mismatch_a", 64'(em_a), 64'h2);
    check("corrupt.fail_cnt_a", 64'(cnt_a), 64'h0000_0100);
    check("corrupt.irq_a", 64'(irq_a), 64'h1);
    wait_n(2);
    check("corrupt.err_mismatch_b", 64'(em_b), 64'h2);
    check("corrupt.fail_cnt_b", 64'(cnt_b), 64'h04);

    // Protocol errors on ch2
    pwr_on[2] = 1'b0; cyc();
    check("proto.err_proto", 64'(ep_a[2]), 64'h1);
    check("proto.state_off", 64'(st_a[8:6]), 64'd2);
    restore[2] = 1'b1; cyc(); restore[2] = 1'b0;
    check("proto.still_set", 64'(ep_a[2]), 64'h1);
    pwr_on[2] = 1'b1; cyc();
    restore[2] = 1'b1; cyc(); restore[2] = 1'b0;
    wait_n(2);
    check("proto.chk_done", 64'(done_a), 64'h4);
    check("proto.no_mismatch", 64'(em_a[2]), 64'h0);
    wait_n(2);

    // Saturation with CNT_W=2 (dut_b) and clear colliding with a mismatch
    clr = 1'b1; cyc(); clr = 1'b0;
    check("clr.irq_b", 64'(irq_b), 64'h0);
    check("clr.fail_cnt_a", 64'(cnt_a), 64'h0);
    for (int k = 0; k < 5; k++) begin
      set_data(1, 32'hA5A5_0000 + 32'(k));
      save[1] = 1'b1; cyc(); save[1] = 1'b0;
      set_data(1, 32'hA5A5_0001 + 32'(k) ^ 32'h0000_0100);
      restore[1] = 1'b1; cyc(); restore[1] = 1'b0;
      wait_n(4);
    end
    check("sat.fail_cnt_b", 64'(cnt_b), 64'h0C);
    check("sat.fail_cnt_a", 64'(cnt_a), 64'h0000_0500);
    set_data(1, 32'h0000_0055);
    save[1] = 1'b1; cyc(); save[1] = 1'b0;
    set_data(1, 32'h0000_0056);
    restore[1] = 1'b1; cyc(); restore[1] = 1'b0;
    wait_n(3);
    clr = 1'b1; cyc(); clr = 1'b0;
    check("clrwin.fail_cnt_b", 64'(cnt_b), 64'h04);
    check("clrwin.err_mismatch_b", 64'(em_b), 64'h2);
    check("clrwin.irq_b", 64'(irq_b), 64'h1);
    check("clrwin.fail_cnt_a", 64'(cnt_a), 64'h0);
    check("clrwin.err_mismatch_a", 64'(em_a), 64'h0);

    // Abort on ch3 (dut_b, RESTORE_LAT=3)
    set_data(3, 32'h0BAD_F00D);
    save[3] = 1'b1; cyc(); save[3] = 1'b0;
    pwr_on[3] = 1'b0; cyc();
    pwr_on[3] = 1'b1; cyc();
    restore[3] = 1'b1; cyc(); restore[3] = 1'b0;
    wait_n(2);
    pwr_on[3] = 1'b0; cyc();
    check("abort.state_off", 64'(st_b[11:9]), 64'd2);
    check("abort.err_proto", 64'(ep_b[3]), 64'h1);
    check("abort.no_done", 64'(done_b), 64'h0);
    check("abort.fail_cnt", 64'(cnt_b[7:6]), 64'h0);
    pwr_on[3] = 1'b1; wait_n(2);

    // Asynchronous reset while in CHECK
    set_data(0, 32'h1357_9BDF);
    save[0] = 1'b1; cyc(); save[0] = 1'b0;
    restore[0] = 1'b1; cyc(); restore[0] = 1'b0;
    check("areset.in_check", 64'(st_a[2:0]), 64'd4);
    #1 rst_n = 1'b0;
    #1;
    check("areset.ch_state", 64'({st_a, st_b}), 64'h0);
    check("areset.errors", 64'({em_a, ep_a, em_b, ep_b}), 64'h0);
    check("areset.fail_cnt", 64'({cnt_a, cnt_b}), 64'h0);
    check("areset.done_irq", 64'({done_a, done_b, irq_a, irq_b}), 64'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    restore[0] = 1'b1; cyc(); restore[0] = 1'b0;
    check("areset.restore_active_a", 64'(ep_a), 64'h1);
    check("areset.restore_active_b", 64'(ep_b), 64'h1);
    wait_n(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
